// File: rtl/scoot_pkg.sv
// Shared definitions for the scoot world and the scootBot benches that reuse it.
package scoot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SENSE = 2'd1,
        ST_MOVE  = 2'd2,
        ST_DONE  = 2'd3
    } scoot_state_t;

    // Bit positions of the four sense/move directions.
    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

    localparam int          DEF_WIDTH    = 10;
    localparam int          DEF_HEIGHT   = 10;
    localparam logic [9:0]  DEF_INIT_COL = 10'b0010101001;

    // Toroidal neighbour coordinate: coord + delta wrapped into [0, size).
    function automatic int wrapStep(input int coord, input int delta, input int size);
        int v;
        v = coord + delta;
        if (v >= size) begin
            v = v - size;
        end else if (v < 0) begin
            v = v + size;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/scoot_axis_step.sv
// One axis of bot motion: applies inc/dec to a coordinate with wrap-around at SIZE.
module scoot_axis_step #(
    parameter int SIZE = 10,
    parameter int W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic [W-1:0] coord,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nextCoord
);

    localparam logic [W-1:0] MAX_COORD = W'(SIZE - 1);

    // Opposing requests cancel; a single request steps and wraps.
    always_comb begin
        nextCoord = coord;
        case ({inc, dec})
            2'b10:   nextCoord = (coord == MAX_COORD) ? {W{1'b0}} : coord + W'(1);
            2'b01:   nextCoord = (coord == {W{1'b0}}) ? MAX_COORD : coord - W'(1);
            default: nextCoord = coord;
        endcase
    end

endmodule

// File: rtl/scoot_world.sv
// Toroidal item grid walked by scootBot: senses neighbours, collects items, applies moves.
module scoot_world
    import scoot_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                HEIGHT    = DEF_HEIGHT,
    parameter int                NUM_STEPS = 100,
    parameter logic [HEIGHT-1:0] INIT_COL  = DEF_INIT_COL,
    parameter int                XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int                YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mUp,
    input  logic          mRight,
    input  logic          mDown,
    input  logic          mLeft,
    output logic          lUp,
    output logic          lRight,
    output logic          lDown,
    output logic          lLeft,
    output logic [XW-1:0] posX,
    output logic [YW-1:0] posY,
    output logic [7:0]    score,
    output logic [7:0]    stepCount,
    output logic          pickup,
    output logic          busy,
    output logic          done
);

    localparam logic [XW-1:0] START_X    = XW'(WIDTH / 2);
    localparam logic [YW-1:0] START_Y    = YW'(HEIGHT / 2);
    localparam logic [7:0]    LAST_STEP  = 8'(NUM_STEPS);

    scoot_state_t      state;
    logic [HEIGHT-1:0] grid [WIDTH];
    logic [XW-1:0]     nextX;
    logic [YW-1:0]     nextY;
    logic [XW-1:0]     xPlus;
    logic [XW-1:0]     xMinus;
    logic [YW-1:0]     yPlus;
    logic [YW-1:0]     yMinus;
    logic [7:0]        stepInc;
    logic [3:0]        senseBits;

    scoot_axis_step #(.SIZE(WIDTH), .W(XW)) xStep (
        .coord     (posX),
        .inc       (mRight),
        .dec       (mLeft),
        .nextCoord (nextX)
    );

    scoot_axis_step #(.SIZE(HEIGHT), .W(YW)) yStep (
        .coord     (posY),
        .inc       (mUp),
        .dec       (mDown),
        .nextCoord (nextY)
    );

    assign xPlus   = XW'(wrapStep(int'(posX),  1, WIDTH));
    assign xMinus  = XW'(wrapStep(int'(posX), -1, WIDTH));
    assign yPlus   = YW'(wrapStep(int'(posY),  1, HEIGHT));
    assign yMinus  = YW'(wrapStep(int'(posY), -1, HEIGHT));
    assign stepInc = stepCount + 8'd1;

    // Neighbour sense bits, visible only while a run is in progress.
    always_comb begin
        senseBits = 4'b0000;
        if ((state == ST_SENSE) || (state == ST_MOVE)) begin
            senseBits[DIR_UP]    = grid[posX][yPlus];
            senseBits[DIR_DOWN]  = grid[posX][yMinus];
            senseBits[DIR_RIGHT] = grid[xPlus][posY];
            senseBits[DIR_LEFT]  = grid[xMinus][posY];
        end else begin
            senseBits = 4'b0000;
        end
    end

    assign lUp    = senseBits[DIR_UP];
    assign lRight = senseBits[DIR_RIGHT];
    assign lDown  = senseBits[DIR_DOWN];
    assign lLeft  = senseBits[DIR_LEFT];

    // Run FSM with registered status, counters, position and grid contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            posX      <= START_X;
            posY      <= START_Y;
            score     <= 8'd0;
            stepCount <= 8'd0;
            pickup    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                grid[i] <= INIT_COL;
            end
        end else begin
            pickup <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SENSE;
                        busy  <= 1'b1;
                    end
                end
                ST_SENSE: begin
                    if (grid[posX][posY]) begin
                        grid[posX][posY] <= 1'b0;
                        pickup           <= 1'b1;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                    state <= ST_MOVE;
                end
                ST_MOVE: begin
                    posX      <= nextX;
                    posY      <= nextY;
                    stepCount <= stepInc;
                    if (stepInc == LAST_STEP) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_SENSE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
